hx711_reader: RTL and testbench
===============================

// Module: hx711_reader
// PURPOSE
//  Producer end of the RAW_VAL/DATA_VALID interface that feeds tare/calibration and weight logic.
//  Bit-bangs the HX711 24-bit ADC serial protocol: waits for DOUT-low ready, then clocks PD_SCK.
//  Shifts in the 24-bit two's-complement sample MSB first.
//  Issues extra gain/channel pulses and publishes each sample with a 1-cycle DATA_VALID strobe.
//  Also resynchronises/powers down the HX711 by holding PD_SCK high.
// PARAMETERS
//  HALF_PERIOD    100   clk_100MHz cycles per PD_SCK high or low phase (100 -> 500 kHz SCK); >=4
//  GAIN_PULSES    1     pulses after bit 24: 1=chA x128, 2=chB x32, 3=chA x64; legal 1..3
//  RESYNC_CYCLES  8000  PD_SCK-high hold forcing HX711 reset (>60 us); >=6500
// PORTS
//  clk_100MHz   in   1   system clock, all logic on posedge
//  rst_n        in   1   asynchronous active-low reset
//  HX711_DOUT   in   1   HX711 data/ready line, asynchronous to clk_100MHz
//  pwr_dn       in   1   level: request HX711 power-down
//  HX711_PD_SCK out  1   serial clock / power-down to HX711
//  RAW_VAL      out  24  signed, last complete sample
//  DATA_VALID   out  1   one-cycle strobe, RAW_VAL updated same cycle
//  busy         out  1   high while a frame is being clocked (SCK_HI/SCK_LO)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - Outputs: HX711_PD_SCK=1, RAW_VAL=0, DATA_VALID=0, busy=0.
//   - Internal: state=RESYNC, counters=0, shift reg=0.
//   - HX711_PD_SCK goes high immediately on assert.
//  DOUT passes through a 2-flop synchroniser (dout_s); all decisions use dout_s only.
//  FSM:
//   - RESYNC: PD_SCK=1 for RESYNC_CYCLES cycles.
//     Then -> PWRDN if pwr_dn, else -> WAIT_HI.
//   - WAIT_HI: PD_SCK=0.
//     dout_s==1 -> IDLE (re-arm, stops double-read of a stale low).
//     pwr_dn -> PWRDN.
//   - IDLE: PD_SCK=0.
//     pwr_dn -> PWRDN (priority over ready).
//     else dout_s==0 -> SCK_HI with bit_cnt=0.
//   - SCK_HI: PD_SCK=1 for HALF_PERIOD cycles.
//     On the last high cycle, if bit_cnt<24, shift dout_s into LSB (MSB arrives first).
//     Then -> SCK_LO.
//   - SCK_LO: PD_SCK=0 for HALF_PERIOD cycles.
//     On the last low cycle: if bit_cnt==23+GAIN_PULSES -> DONE, else bit_cnt++ and -> SCK_HI.
//   - DONE: one cycle, RAW_VAL<=shift reg, DATA_VALID=1. Then -> WAIT_HI.
//   - PWRDN: PD_SCK=1 while pwr_dn.
//     On deassert -> WAIT_HI; HX711 re-powers and DOUT is high until first conversion.
//  Framing:
//   - Exactly 24+GAIN_PULSES PD_SCK pulses per frame, each high and low exactly HALF_PERIOD cycles.
//   - PD_SCK high never exceeds HALF_PERIOD inside a frame, so no accidental power-down.
//  Latency and edge cases:
//   - Latency: DATA_VALID asserts the cycle after the final low phase ends; it is never high 2 cycles in a row.
//   - pwr_dn during SCK_HI/SCK_LO is ignored until the frame completes and DATA_VALID fires.
//   - DOUT changes mid-frame are simply sampled; there is no abort path.
//   - rst_n mid-frame: no DATA_VALID, RAW_VAL=0; RESYNC realigns the HX711 bit counter.
//   - RAW_VAL holds its value between strobes.
//   - No arithmetic on the sample; bit 23 is the sign (0x800000 = -8388608).
// TESTING
//  1 rst_n low 10 cycles then high -> PD_SCK=1 for 8000 cycles then 0; RAW_VAL=0, DATA_VALID=0 throughout.
//  2 model drives DOUT low, presents 0x7FFFFF -> 25 pulses, 100 hi/100 lo cycles; RAW_VAL=0x7FFFFF; DATA_VALID 1 cycle.
//  3 GAIN_PULSES=3, sample 0x800000 -> 27 pulses; RAW_VAL=-8388608; next frame starts only after DOUT high->low.
//  4 pwr_dn raised at bit 10 of 0x123456 -> frame completes, RAW_VAL=0x123456, then PD_SCK held 1.
//    Drop pwr_dn -> PD_SCK 0; next ready frame read normally.
//  5 rst_n pulsed at bit 12 -> PD_SCK 1 at once, no DATA_VALID, RAW_VAL=0.
//    After RESYNC, frame 0xABCDEF -> RAW_VAL=0xABCDEF.
//  6 DOUT held low after a frame -> no second frame and PD_SCK stays 0 until DOUT seen high then low again.

Source files
------------

// File: rtl/hx711_reader_if.sv
// rtl/hx711_reader_if.sv - sample publication bundle from the HX711 reader
interface hx711_reader_if;
    logic signed [23:0] RAW_VAL;
    logic               DATA_VALID;
    logic               busy;

    modport master (output RAW_VAL, output DATA_VALID, output busy);
    modport slave  (input  RAW_VAL, input  DATA_VALID, input  busy);
endinterface

// File: rtl/hx711_reader.sv
// rtl/hx711_reader.sv - HX711 24-bit ADC serial reader with gain pulses and power-down
module hx711_reader #(
    parameter int HALF_PERIOD   = 100,
    parameter int GAIN_PULSES   = 1,
    parameter int RESYNC_CYCLES = 8000
) (
    input  logic              clk_100MHz,
    input  logic              rst_n,
    input  logic              HX711_DOUT,
    input  logic              pwr_dn,
    output logic              HX711_PD_SCK,
    hx711_reader_if.master    out_if
);

    localparam int CNT_MAX = (RESYNC_CYCLES > HALF_PERIOD) ? RESYNC_CYCLES : HALF_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        RESYNC,
        WAIT_HI,
        IDLE,
        SCK_HI,
        SCK_LO,
        DONE,
        PWRDN
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    logic [4:0]         bit_q, bit_d;
    logic [23:0]        shift_q, shift_d;
    logic signed [23:0] raw_q, raw_d;
    logic               dv_q, dv_d;
    logic               sck_q, sck_d;
    logic               busy_q, busy_d;
    logic               dout_meta_q, dout_s_q;

    // Two-flop synchroniser for DOUT; idles high (not ready) out of reset
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            dout_meta_q <= 1'b1;
            dout_s_q    <= 1'b1;
        end else begin
            dout_meta_q <= HX711_DOUT;
            dout_s_q    <= dout_meta_q;
        end
    end

    // Next-state logic; PD_SCK, busy and the strobe follow the next state so they come straight from flops
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        raw_d   = raw_q;

        case (state_q)
            RESYNC: begin
                if (cyc_q == CW'(RESYNC_CYCLES - 1)) begin
                    cyc_d   = '0;
                    state_d = pwr_dn ? PWRDN : WAIT_HI;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            WAIT_HI: begin
                // A low DOUT left over from the last frame must not start another read
                if (dout_s_q) begin
                    state_d = IDLE;
                end else if (pwr_dn) begin
                    state_d = PWRDN;
                end
            end
            IDLE: begin
                if (pwr_dn) begin
                    state_d = PWRDN;
                end else if (!dout_s_q) begin
                    state_d = SCK_HI;
                    bit_d   = '0;
                    cyc_d   = '0;
                    shift_d = '0;
                end
            end
            SCK_HI: begin
                if (cyc_q == CW'(HALF_PERIOD - 1)) begin
                    cyc_d = '0;
                    // Gain/channel pulses carry no data, so only the first 24 are shifted
                    if (bit_q < 5'd24) begin
                        shift_d = {shift_q[22:0], dout_s_q};
                    end
                    state_d = SCK_LO;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            SCK_LO: begin
                if (cyc_q == CW'(HALF_PERIOD - 1)) begin
                    cyc_d = '0;
                    if (bit_q == 5'(23 + GAIN_PULSES)) begin
                        state_d = DONE;
                        raw_d   = shift_q;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        state_d = SCK_HI;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DONE: begin
                state_d = WAIT_HI;
            end
            PWRDN: begin
                // HX711 comes back with DOUT high, so WAIT_HI re-arms cleanly
                if (!pwr_dn) begin
                    state_d = WAIT_HI;
                end
            end
            default: begin
                state_d = RESYNC;
                cyc_d   = '0;
            end
        endcase

        sck_d  = (state_d == RESYNC) || (state_d == SCK_HI) || (state_d == PWRDN);
        busy_d = (state_d == SCK_HI) || (state_d == SCK_LO);
        dv_d   = (state_d == DONE);
    end

    // State and registered outputs; PD_SCK is forced high as soon as reset asserts
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESYNC;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            raw_q   <= '0;
            dv_q    <= 1'b0;
            sck_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            raw_q   <= raw_d;
            dv_q    <= dv_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
        end
    end

    assign HX711_PD_SCK      = sck_q;
    assign out_if.RAW_VAL    = raw_q;
    assign out_if.DATA_VALID = dv_q;
    assign out_if.busy       = busy_q;

endmodule

// File: tb/tb_hx711_reader.sv
// tb/tb_hx711_reader.sv - self-checking bench for hx711_reader with a behavioural HX711
module tb_hx711_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic dout_a, dout_b;
    logic pwr_dn_a, pwr_dn_b;
    logic sck_a, sck_b;
    logic sel;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    hx711_reader_if if_a ();
    hx711_reader_if if_b ();

    hx711_reader #(.HALF_PERIOD(100), .GAIN_PULSES(1), .RESYNC_CYCLES(8000)) dut_a (
        .clk_100MHz   (clk),
        .rst_n        (rst_n),
        .HX711_DOUT   (dout_a),
        .pwr_dn       (pwr_dn_a),
        .HX711_PD_SCK (sck_a),
        .out_if       (if_a)
    );

    hx711_reader #(.HALF_PERIOD(4), .GAIN_PULSES(3), .RESYNC_CYCLES(8000)) dut_b (
        .clk_100MHz   (clk),
        .rst_n        (rst_n),
        .HX711_DOUT   (dout_b),
        .pwr_dn       (pwr_dn_b),
        .HX711_PD_SCK (sck_b),
        .out_if       (if_b)
    );

    always #5 clk = ~clk;

    wire        sck_m  = sel ? sck_b : sck_a;
    wire        dv_m   = sel ? if_b.DATA_VALID : if_a.DATA_VALID;
    wire        busy_m = sel ? if_b.busy : if_a.busy;
    wire [23:0] raw_m  = sel ? if_b.RAW_VAL : if_a.RAW_VAL;

    // Releases reset at the current negedge and times the RESYNC high phase on both DUTs
    task automatic check_resync();
        int ca, cb, bad;
        ca = 0; cb = 0; bad = 0;
        rst_n = 1'b1;
        for (int c = 0; c < 8100 && (sck_a || sck_b); c++) begin
            if (sck_a) ca++;
            if (sck_b) cb++;
            if (if_a.DATA_VALID || if_b.DATA_VALID || if_a.RAW_VAL != 0 || if_b.RAW_VAL != 0) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (ca !== 8000) begin n_bad++; $display("FAIL resync_len_a: got %0d expected 8000", ca); end
        n_cmp++;
        if (cb !== 8000) begin n_bad++; $display("FAIL resync_len_b: got %0d expected 8000", cb); end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL resync_quiet: got %0d bad cycles expected 0", bad); end
    endtask

    // Behavioural HX711 frame: presents w, measures SCK framing, scores RAW_VAL on DATA_VALID
    task automatic run_frame(input logic [23:0] w, input int gp, input int hp,
                             input bit raise_after, input int pd_at, input int rst_at);
        int rises, hi, lo, bad, budget;
        bit prev, cur, done, aborted;
        logic [23:0] exp;
        exp_q.push_back(w);
        if (sel) dout_b = 1'b0; else dout_a = 1'b0;
        rises = 0; hi = 0; lo = 0; bad = 0; done = 0; aborted = 0;
        prev = sck_m;
        budget = hp * 2 * 28 + 400;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            cur = sck_m;
            if (dv_m) begin
                done = 1;
                n_cmp++;
                if (lo !== hp) begin n_bad++; $display("FAIL last_low_width: got %0d expected %0d", lo, hp); end
                n_cmp++;
                if (rises !== 24 + gp) begin n_bad++; $display("FAIL pulse_count: got %0d expected %0d", rises, 24 + gp); end
                n_cmp++;
                if (bad !== 0) begin n_bad++; $display("FAIL phase_width: got %0d bad phases expected 0", bad); end
                n_cmp++;
                if (busy_m !== 1'b0) begin n_bad++; $display("FAIL busy_done: got %0b expected 0", busy_m); end
                exp = exp_q.pop_front();
                n_cmp++;
                if (raw_m !== exp) begin n_bad++; $display("FAIL raw_val: got %06h expected %06h", raw_m, exp); end
            end else begin
                if (cur && !prev) begin
                    if (rises > 0 && lo != hp) bad++;
                    if (rises == 0) begin
                        n_cmp++;
                        if (busy_m !== 1'b1) begin n_bad++; $display("FAIL busy_frame: got %0b expected 1", busy_m); end
                    end
                    if (rises < 24) begin
                        if (sel) dout_b = w[23 - rises]; else dout_a = w[23 - rises];
                    end else if (raise_after) begin
                        if (sel) dout_b = 1'b1; else dout_a = 1'b1;
                    end
                    rises++;
                    hi = 0;
                    if (rises == pd_at) pwr_dn_a = 1'b1;
                end else if (!cur && prev) begin
                    if (hi != hp) bad++;
                    lo = 0;
                    if (rises == rst_at) begin
                        rst_n = 1'b0;
                        #1;
                        n_cmp++;
                        if (sck_m !== 1'b1) begin n_bad++; $display("FAIL rst_sck: got %0b expected 1", sck_m); end
                        n_cmp++;
                        if (raw_m !== 24'h0 || dv_m !== 1'b0) begin
                            n_bad++; $display("FAIL rst_outputs: got raw %06h dv %0b expected 0 0", raw_m, dv_m);
                        end
                        for (int k = 0; k < 5; k++) begin
                            @(negedge clk);
                            if (dv_m || !sck_m) bad++;
                        end
                        n_cmp++;
                        if (bad !== 0) begin n_bad++; $display("FAIL rst_hold: got %0d bad expected 0", bad); end
                        void'(exp_q.pop_front());
                        if (sel) dout_b = 1'b1; else dout_a = 1'b1;
                        aborted = 1;
                        done = 1;
                    end
                end
                if (cur) hi++; else lo++;
            end
            prev = cur;
        end
        if (!aborted) begin
            if (!done) begin
                n_cmp++; n_bad++;
                $display("FAIL frame_timeout: got no DATA_VALID expected one within %0d cycles", budget);
            end else begin
                @(negedge clk);
                n_cmp++;
                if (dv_m !== 1'b0) begin n_bad++; $display("FAIL dv_one_cycle: got %0b expected 0", dv_m); end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (sck_a !== 1'b1 || sck_b !== 1'b1) begin n_bad++; $display("FAIL reset_sck: got %0b%0b expected 11", sck_a, sck_b); end
        n_cmp++;
        if (if_a.RAW_VAL !== 24'sd0 || if_a.DATA_VALID !== 1'b0 || if_a.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs: got %06h %0b %0b expected 000000 0 0", if_a.RAW_VAL, if_a.DATA_VALID, if_a.busy);
        end
        check_resync();
    endtask

    task automatic test_basic_frame();
        sel = 1'b0;
        run_frame(24'h7FFFFF, 1, 100, 1'b1, 0, 0);
        n_cmp++;
        if (if_a.RAW_VAL !== 24'sh7FFFFF) begin n_bad++; $display("FAIL basic_raw: got %06h expected 7fffff", if_a.RAW_VAL); end
    endtask

    task automatic test_gain3_negative();
        int bad;
        sel = 1'b1;
        run_frame(24'h800000, 3, 4, 1'b1, 0, 0);
        n_cmp++;
        if (int'(if_b.RAW_VAL) !== -8388608) begin n_bad++; $display("FAIL neg_raw: got %0d expected -8388608", int'(if_b.RAW_VAL)); end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sck_b || if_b.DATA_VALID) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL dout_high_idle: got %0d active cycles expected 0", bad); end
        run_frame(24'h000001, 3, 4, 1'b1, 0, 0);
    endtask

    task automatic test_pwr_dn();
        int bad;
        sel = 1'b0;
        run_frame(24'h123456, 1, 100, 1'b1, 10, 0);
        repeat (3) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (!sck_a || if_a.DATA_VALID || if_a.busy) bad++;
            @(negedge clk);
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL pwrdn_hold: got %0d bad cycles expected 0", bad); end
        n_cmp++;
        if (if_a.RAW_VAL !== 24'sh123456) begin n_bad++; $display("FAIL pwrdn_raw: got %06h expected 123456", if_a.RAW_VAL); end
        pwr_dn_a = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sck_a !== 1'b0) begin n_bad++; $display("FAIL pwrdn_release: got %0b expected 0", sck_a); end
        run_frame(24'h00C0DE, 1, 100, 1'b1, 0, 0);
    endtask

    task automatic test_reset_midframe();
        sel = 1'b0;
        run_frame(24'hFEDCBA, 1, 100, 1'b1, 0, 12);
        check_resync();
        run_frame(24'hABCDEF, 1, 100, 1'b1, 0, 0);
    endtask

    task automatic test_back_to_back();
        int bad;
        sel = 1'b0;
        run_frame(24'h5A5A5A, 1, 100, 1'b0, 0, 0);
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (sck_a || if_a.DATA_VALID) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_bad++; $display("FAIL stale_low: got %0d active cycles expected 0", bad); end
        n_cmp++;
        if (if_a.RAW_VAL !== 24'sh5A5A5A) begin n_bad++; $display("FAIL raw_hold: got %06h expected 5a5a5a", if_a.RAW_VAL); end
        dout_a = 1'b1;
        repeat (5) @(negedge clk);
        run_frame(24'h0F0F0F, 1, 100, 1'b1, 0, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        dout_a   = 1'b1;
        dout_b   = 1'b1;
        pwr_dn_a = 1'b0;
        pwr_dn_b = 1'b0;
        sel      = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_gain3_negative();
        test_pwr_dn();
        test_reset_midframe();
        test_back_to_back();
        n_cmp++;
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
